// File: rtl/booth_sched_pkg.sv
// Shared types and constants for the Booth multiplier scheduler.
package booth_sched_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int PWR_W  = 8;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_LOW    = 2'b01;
    localparam logic [1:0] MODE_ULTRA  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

    // The reserved encoding 11 is run as normal mode.
    function automatic logic [1:0] sanitize_mode(input logic [1:0] mode);
        return (mode == 2'b11) ? MODE_NORMAL : mode;
    endfunction

endpackage

// File: rtl/booth_mult_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    int  idx;
    logic found;

    // Scan N_REQ slots starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Shares one signed Booth multiplier between N_REQ requesters, one job at a time.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | arbitrate; latch operands of the granted requester
// ST_ISSUE | pulse mul_start, clear wait counter
// ST_WAIT  | wait for mul_done under the timeout watchdog
// ST_RESP  | hold response until rsp_ready
module booth_mult_scheduler
    import booth_sched_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 32,
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                gated_clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [8*N_REQ-1:0]  req_a,
    input  logic [8*N_REQ-1:0]  req_b,
    input  logic [2*N_REQ-1:0]  req_mode,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [PROD_W-1:0]   rsp_product,
    output logic [PWR_W-1:0]    rsp_power,
    output logic                rsp_err,
    output logic                mul_start,
    output logic [OP_W-1:0]     mul_a,
    output logic [OP_W-1:0]     mul_b,
    output logic [1:0]          mul_mode,
    input  logic                mul_done,
    input  logic [PROD_W-1:0]   mul_product,
    input  logic [PWR_W-1:0]    mul_power,
    output logic                busy
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    sched_state_e       state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic [PWR_W-1:0]   pwr_q, pwr_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic [OP_W-1:0]    sel_a, sel_b;
    logic [1:0]         sel_mode;

    // Grants are suppressed while reset is asserted so req_ready reads 0 too.
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .en        ((state_q == ST_IDLE) && !reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Operand mux for the granted requester.
    always_comb begin
        sel_a    = req_a[8*int'(grant_idx) +: 8];
        sel_b    = req_b[8*int'(grant_idx) +: 8];
        sel_mode = req_mode[2*int'(grant_idx) +: 2];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        pwr_d    = pwr_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    a_d      = sel_a;
                    b_d      = sel_b;
                    mode_d   = sanitize_mode(sel_mode);
                    id_d     = grant_idx;
                    rr_ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    prod_d  = mul_product;
                    pwr_d   = mul_power;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    prod_d  = '0;
                    pwr_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight job.
    always_ff @(posedge gated_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            pwr_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            pwr_q    <= pwr_d;
            err_q    <= err_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        req_ready   = grant;
        mul_start   = (state_q == ST_ISSUE);
        rsp_valid   = (state_q == ST_RESP);
        busy        = (state_q != ST_IDLE);
        mul_a       = a_q;
        mul_b       = b_q;
        mul_mode    = mode_q;
        rsp_id      = id_q;
        rsp_product = prod_q;
        rsp_power   = pwr_q;
        rsp_err     = err_q;
    end

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Bench for booth_mult_scheduler with a behavioural multiplier and response scoreboard.
module tb_booth_mult_scheduler;
    import booth_sched_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 32;

    logic        gated_clk = 1'b0;
    logic        reset     = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_a     = '0;
    logic [31:0] req_b     = '0;
    logic [7:0]  req_mode  = '0;
    logic        rsp_ready = 1'b1;
    logic [3:0]  req_ready;
    logic        rsp_valid, rsp_err, mul_start, busy, mul_done;
    logic [1:0]  rsp_id, mul_mode;
    logic [15:0] rsp_product, mul_product;
    logic [7:0]  rsp_power, mul_power, mul_a, mul_b;

    booth_mult_scheduler #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .gated_clk   (gated_clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_mode    (req_mode),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_power   (rsp_power),
        .rsp_err     (rsp_err),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_mode    (mul_mode),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .mul_power   (mul_power),
        .busy        (busy)
    );

    always #5 gated_clk = ~gated_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction

    function automatic logic [7:0] pwr_exp(input logic [1:0] m);
        case (m)
            2'b01:   return 8'd60;
            2'b10:   return 8'd30;
            default: return 8'd100;
        endcase
    endfunction

    // Behavioural multiplier: done in the 10th cycle after the start cycle.
    int          dly = 0;
    logic [7:0]  ma = '0, mb = '0;
    logic [1:0]  mm = '0;
    logic        mdl_done = 1'b0, inj_done = 1'b0, never_done = 1'b0;
    logic [15:0] mdl_prod = 16'h1234;
    logic [7:0]  mdl_pwr  = 8'h77;

    assign mul_done    = mdl_done | inj_done;
    assign mul_product = mdl_prod;
    assign mul_power   = mdl_pwr;

    always @(negedge gated_clk) begin
        if (reset) begin
            dly      = 0;
            mdl_done = 1'b0;
        end else begin
            if (mul_start) begin
                dly = 1;
                ma  = mul_a;
                mb  = mul_b;
                mm  = mul_mode;
            end else if (dly != 0) begin
                dly = (dly == 11) ? 0 : dly + 1;
            end
            mdl_done = (dly == 11) && !never_done;
            if (mdl_done) begin
                mdl_prod = smul(ma, mb);
                case (mm)
                    2'b00:   mdl_pwr = 8'd100;
                    2'b01:   mdl_pwr = 8'd60;
                    2'b10:   mdl_pwr = 8'd30;
                    default: mdl_pwr = 8'hFF;
                endcase
            end
        end
    end

    // Scoreboard and grant monitor.
    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] prod;
        logic [7:0]  pwr;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   gq[$];
    int   start_cnt = 0;
    rsp_t e_mon;

    always @(negedge gated_clk) begin
        if (!reset) begin
            if (mul_start) start_cnt++;
            if (req_ready != 4'b0000) begin
                chk("grant_onehot", 64'($onehot(req_ready)), 64'd1);
                chk("grant_is_valid", 64'(|(req_ready & req_valid)), 64'd1);
                for (int i = 0; i < N; i++) if (req_ready[i]) gq.push_back(i);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got id %0d, expected no response", rsp_id);
                end else begin
                    e_mon = sb.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e_mon.id));
                    chk("rsp_product", 64'(rsp_product), 64'(e_mon.prod));
                    chk("rsp_power", 64'(rsp_power), 64'(e_mon.pwr));
                    chk("rsp_err", 64'(rsp_err), 64'(e_mon.err));
                end
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return 64'({req_ready, rsp_valid, busy, mul_start, rsp_err, rsp_id,
                    rsp_product, rsp_power, mul_a, mul_b, mul_mode});
    endfunction

    task automatic drive_req(input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] m);
        @(posedge gated_clk);
        #1;
        req_a[8*id +: 8]  = a;
        req_b[8*id +: 8]  = b;
        req_mode[2*id +: 2] = m;
        req_valid[id]     = 1'b1;
    endtask

    task automatic wait_grant(input int id);
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge gated_clk);
            if (req_ready[id]) break;
        end
        if (k == 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: requester %0d got no req_ready, expected one", id);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            @(posedge gated_clk);
            if (sb.size() == 0 && !busy) break;
        end
        #1;
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
        logic [15:0] prod;
        logic [1:0] mmode;
    } vec_t;

    // Single request: start one cycle after accept, response 12 cycles after accept.
    task automatic run_vec(input vec_t v);
        int lat;
        int s0;
        s0 = start_cnt;
        sb.push_back('{id: 2'(v.id), prod: v.prod, pwr: pwr_exp(v.mode), err: 1'b0});
        drive_req(v.id, v.a, v.b, v.mode);
        wait_grant(v.id);
        @(posedge gated_clk);
        #1;
        req_valid[v.id] = 1'b0;
        lat = 0;
        do begin
            @(negedge gated_clk);
            lat++;
            if (lat == 1) begin
                chk("mul_start_c1", 64'(mul_start), 64'd1);
                chk("mul_mode", 64'(mul_mode), 64'(v.mmode));
                chk("mul_a", 64'(mul_a), 64'(v.a));
                chk("mul_b", 64'(mul_b), 64'(v.b));
            end
        end while (!rsp_valid && lat < 60);
        chk("accept_to_rsp", 64'(lat), 64'd12);
        @(posedge gated_clk);
        #1;
        chk("one_start_pulse", 64'(start_cnt - s0), 64'd1);
    endtask

    vec_t tbl[6];
    int   rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    logic [63:0] snap;
    int   lat, lat_start;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 8'd5,   8'd3,   2'b01, 16'h000F, 2'b01};
        tbl[1] = '{1, 8'hFB,  8'hFD,  2'b11, 16'h000F, 2'b00};
        tbl[2] = '{2, 8'hFB,  8'h03,  2'b00, 16'hFFF1, 2'b00};
        tbl[3] = '{3, 8'h80,  8'h80,  2'b10, 16'h4000, 2'b10};
        tbl[4] = '{0, 8'h7F,  8'h80,  2'b01, 16'hC080, 2'b01};
        tbl[5] = '{3, 8'h00,  8'h9C,  2'b11, 16'h0000, 2'b00};

        // Reset with all requesters already valid: outputs must read 0.
        for (int i = 0; i < N; i++) begin
            req_a[8*i +: 8]   = 8'(i * 10 + 1);
            req_b[8*i +: 8]   = 8'(-(i + 2));
            req_mode[2*i +: 2] = 2'(i);
        end
        req_valid = 4'hF;
        #12;
        chk("reset_outputs", all_outs(), 64'd0);

        // Round robin from reset.
        for (int k = 0; k < 6; k++) begin
            int r;
            r = rr_exp[k];
            sb.push_back('{id: 2'(r), prod: smul(8'(r * 10 + 1), 8'(-(r + 2))),
                           pwr: pwr_exp(2'(r)), err: 1'b0});
        end
        @(posedge gated_clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge gated_clk);
            if (gq.size() >= 6) break;
        end
        #1;
        req_valid = 4'h0;
        drain();
        chk("rr_grant_count", 64'(gq.size()), 64'd6);
        for (int k = 0; k < 6; k++)
            if (k < gq.size()) chk("rr_order", 64'(gq[k]), 64'(rr_exp[k]));
        gq.delete();

        // Table-driven single requests.
        for (int k = 0; k < 6; k++) run_vec(tbl[k]);
        drain();

        // Backpressure: hold RESP while another requester waits.
        rsp_ready = 1'b0;
        sb.push_back('{id: 2'd1, prod: 16'hFFF2, pwr: 8'd60, err: 1'b0});
        sb.push_back('{id: 2'd2, prod: 16'd12, pwr: 8'd30, err: 1'b0});
        drive_req(1, 8'd7, 8'hFE, 2'b01);
        wait_grant(1);
        @(posedge gated_clk);
        #1;
        req_valid[1]  = 1'b0;
        req_a[23:16]  = 8'd3;
        req_b[23:16]  = 8'd4;
        req_mode[5:4] = 2'b10;
        req_valid[2]  = 1'b1;
        lat = 0;
        do begin
            @(negedge gated_clk);
            lat++;
        end while (!rsp_valid && lat < 60);
        chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
        snap = 64'({rsp_id, rsp_product, rsp_power, rsp_err});
        for (int k = 0; k < 5; k++) begin
            @(negedge gated_clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_stable", 64'({rsp_id, rsp_product, rsp_power, rsp_err}), snap);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_no_start", 64'(mul_start), 64'd0);
        end
        @(posedge gated_clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge gated_clk);
        chk("bp_release_rsp", 64'(rsp_valid), 64'd1);
        @(negedge gated_clk);
        chk("bp_idle_busy", 64'(busy), 64'd0);
        chk("bp_idle_grant", 64'(req_ready), 64'b0100);
        @(posedge gated_clk);
        #1;
        req_valid[2] = 1'b0;
        drain();

        // Timeout: multiplier never answers; a late done in RESP is ignored.
        never_done = 1'b1;
        rsp_ready  = 1'b0;
        sb.push_back('{id: 2'd3, prod: 16'd0, pwr: 8'd0, err: 1'b1});
        drive_req(3, 8'd9, 8'd9, 2'b00);
        wait_grant(3);
        @(posedge gated_clk);
        #1;
        req_valid[3] = 1'b0;
        lat = 0;
        lat_start = -100;
        do begin
            @(negedge gated_clk);
            lat++;
            if (mul_start) lat_start = lat;
        end while (!rsp_valid && lat < 80);
        chk("timeout_latency", 64'(lat - lat_start), 64'(TMO + 1));
        chk("timeout_err", 64'(rsp_err), 64'd1);
        chk("timeout_prod", 64'(rsp_product), 64'd0);
        chk("timeout_pwr", 64'(rsp_power), 64'd0);
        @(posedge gated_clk);
        #1;
        inj_done = 1'b1;
        @(posedge gated_clk);
        #1;
        inj_done = 1'b0;
        @(negedge gated_clk);
        chk("late_done_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("late_done_err", 64'(rsp_err), 64'd1);
        chk("late_done_prod", 64'(rsp_product), 64'd0);
        @(posedge gated_clk);
        #1;
        rsp_ready  = 1'b1;
        never_done = 1'b0;
        drain();
        run_vec('{2, 8'd6, 8'd7, 2'b01, 16'd42, 2'b01});
        drain();

        // Reset in the middle of WAIT: job discarded, pointer back to 0.
        drive_req(2, 8'd11, 8'd11, 2'b00);
        wait_grant(2);
        @(posedge gated_clk);
        #1;
        req_valid[2] = 1'b0;
        repeat (4) @(posedge gated_clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midwait_reset_outputs", all_outs(), 64'd0);
        req_a[31:16]  = {8'd2, 8'd4};
        req_b[31:16]  = {8'hFF, 8'd5};
        req_mode[7:4] = 4'b0000;
        req_valid     = 4'b1100;
        #2;
        chk("midwait_reset_ready", 64'(req_ready), 64'd0);
        gq.delete();
        sb.push_back('{id: 2'd2, prod: 16'd20, pwr: 8'd100, err: 1'b0});
        sb.push_back('{id: 2'd3, prod: 16'hFFFE, pwr: 8'd100, err: 1'b0});
        @(posedge gated_clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge gated_clk);
            if (gq.size() >= 1) break;
        end
        #1;
        req_valid[2] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge gated_clk);
            if (gq.size() >= 2) break;
        end
        #1;
        req_valid[3] = 1'b0;
        drain();
        chk("post_reset_grants", 64'(gq.size()), 64'd2);
        if (gq.size() >= 2) begin
            chk("post_reset_first", 64'(gq[0]), 64'd2);
            chk("post_reset_second", 64'(gq[1]), 64'd3);
        end

        repeat (3) @(posedge gated_clk);
        #1;
        chk("final_idle", 64'({busy, rsp_valid, req_ready}), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/booth_mult_scheduler.md
# booth_mult_scheduler

Round-robin scheduler that shares one 8-bit signed Booth multiplier between `N_REQ` requesters. It accepts one request at a time and drives the multiplier's `start`/operand/`power_mode` inputs. It waits for `done` under a timeout watchdog and returns the product, power estimate and requester ID on a held valid/ready response channel. It sits between client blocks and the multiplier, in the multiplier's gated-clock domain.

## Interface
- `N_REQ`, 4: number of requesters (2..8). `ID_W` = max(1, clog2(N_REQ)).
- `TIMEOUT`, 32: WAIT cycles allowed before an error response (4..255).
- Clocking: reset is asynchronous and active-high; the block is clocked by gated_clk.
- `gated_clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester request.
- `req_ready`  out  N_REQ  one-hot accept strobe.
- `req_a`  in  8*N_REQ  signed multiplicands, requester i at [8i+7:8i].
- `req_b`  in  8*N_REQ  signed multipliers, same packing.
- `req_mode`  in  2*N_REQ  power mode (00 normal, 01 low, 10 ultra-low, 11 reserved).
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  ID_W  index of the requester served.
- `rsp_product`  out  16  signed product.
- `rsp_power`  out  8  multiplier power_consumption snapshot.
- `rsp_err`  out  1  timeout flag.
- `mul_start`  out  1  one-cycle start pulse.
- `mul_a`, `mul_b`  out  8 each  operands.
- `mul_mode`  out  2  power mode to the multiplier.
- `mul_done`  in  1  multiplier completion.
- `mul_product`  in  16  multiplier product.
- `mul_power`  in  8  multiplier power_consumption.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Round-robin search starts at `rr_ptr` and wraps modulo N_REQ.
  - The first requester with `req_valid` high is granted. `req_ready` is combinational and equals grant one-hot only in IDLE, otherwise all zero.
  - On grant: latch operands, mode and ID; set `rr_ptr` = grant+1 mod N_REQ; go to ISSUE.
  - `req_mode` = 11 is latched as 00.
- ISSUE: `mul_start` = 1 for exactly this cycle. Clear the wait counter; go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - If `mul_done` = 1: capture `mul_product` and `mul_power`, set err = 0, go to RESP.
  - Else if counter = TIMEOUT-1: product = 0, power = 0, err = 1, go to RESP.
  - `mul_done` wins when it coincides with the timeout cycle.
- RESP: `rsp_valid` = 1 with all rsp fields stable until `rsp_valid && rsp_ready` at an edge; then go to IDLE.
- `mul_a`, `mul_b` and `mul_mode` are registered. They are held from ISSUE through RESP and keep their value in IDLE until the next grant.
- `mul_done` outside WAIT is ignored. A late done after a timeout is dropped.
- Requesters hold `req_valid` and operands stable until their `req_ready` is seen. Dropping valid before grant is legal, and that requester is skipped.
- Reset values:
  - All outputs are 0.
  - `rr_ptr` = 0, state = IDLE.
  - Any in-flight transaction is discarded with no response. The multiplier shares the same reset.

## Timing
- Accept at edge C0. `mul_start` is high during C1. Responses are returned in accept order.
- If `mul_done` is sampled high at edge Cd, `rsp_valid` is high from Cd+1.
- Zero-wait turnaround: RESP handshake at edge Cr → IDLE in cycle Cr+1, next accept possible at Cr+1. Minimum spacing between `mul_start` pulses is therefore ≥ 3 cycles beyond multiplier latency, which guarantees the multiplier has returned to its idle state.
- With the nominal multiplier (done about 10 cycles after start), accept-to-`rsp_valid` is 12 cycles.
- Timeout: `rsp_valid` rises TIMEOUT+1 cycles after `mul_start`.

## Structure
- Package `booth_sched_pkg`:
  - state enum;
  - `OP_W` = 8, `PROD_W` = 16, `PWR_W` = 8;
  - mode constants `MODE_NORMAL`, `MODE_LOW`, `MODE_ULTRA`;
  - mode sanitising function (11 → 00).
- Sub-module `rr_arbiter` (N_REQ parameter): inputs req vector, ptr, enable; outputs grant one-hot and grant index. Purely combinational; the FSM owns `rr_ptr`.

## Test plan
- Single request: req0 a = 5, b = 3, mode 01, with a behavioural multiplier model that asserts done 10 cycles after start.
  - `mul_start` pulses once, 1 cycle after accept, with `mul_mode` = 01.
  - Response: `rsp_id` = 0, `rsp_product` = 15, `rsp_err` = 0.
- Signed operands: a = 0xFB (−5), b = 0xFD (−3), mode 11 → `mul_mode` = 00, `rsp_product` = 0x000F. Then a = 0xFB, b = 3 → `rsp_product` = 0xFFF1.
- Round-robin: all 4 `req_valid` held high from reset.
  - Grant order 0, 1, 2, 3, 0, 1.
  - Each `req_ready` is one-hot for exactly one cycle per transaction; `rsp_id` follows the same order.
- Backpressure: `rsp_ready` held low 6 cycles in RESP.
  - `rsp_*` stay stable, `req_ready` stays 0, `busy` = 1, no `mul_start`.
  - Release → IDLE next cycle.
- Timeout: model never asserts done.
  - `rsp_valid` rises 33 cycles after `mul_start` with `rsp_err` = 1, product 0, power 0.
  - A late done injected in RESP is ignored; the next request completes with err = 0.
- Reset asserted mid-WAIT: outputs go to 0 asynchronously and no response is produced. After deassert, req2 alone is granted first (ptr = 0 search).
